// File: rtl/prt_frame_tx.sv
// Egress drain engine: opens a PRT slot, streams its bytes out on a valid/ready
// interface with tx_last, then invalidates the slot. Define PRT_TX_STATS_EN for frame/byte counters.
module prt_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 2,
  parameter int MAX_FRAME  = 1518,
  parameter int FIFO_DEPTH = 4,
  localparam int SLOT_WIDTH = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [SLOT_WIDTH-1:0] slot_in,
  input  logic                  slot_in_valid,
  output logic                  slot_in_ready,
  output logic                  EN_start_reading_prt_entry,
  output logic [SLOT_WIDTH-1:0] start_reading_prt_entry_slot,
  input  logic                  RDY_start_reading_prt_entry,
  output logic                  EN_read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  input  logic [DATA_WIDTH:0]   read_prt_entry,
  output logic                  EN_invalidate_prt_entry,
  output logic [SLOT_WIDTH-1:0] invalidate_prt_entry_slot,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err_overrun,
  output logic [15:0]           frames_sent,
  output logic [15:0]           bytes_sent
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_INVAL} state_t;

  state_t                r_state;
  logic [SLOT_WIDTH-1:0] r_cur_slot;
  logic                  r_inflight;
  logic                  r_stage_vld;
  logic [DATA_WIDTH-1:0] r_stage;
  logic [CW-1:0]         r_byte_cnt;
  logic                  r_err;

  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_fifo_cnt;

  logic w_resp, w_resp_cmpl, w_resp_data;
  logic w_at_cap, w_hit_cap, w_credit, w_room, w_slot_free;
  logic w_en_read, w_ovr_push, w_push, w_pop, w_push_last, w_fifo_vld;
  logic [DATA_WIDTH:0] w_head;

  assign w_resp      = (r_state == S_READ) && r_inflight;
  assign w_resp_cmpl = w_resp &&  read_prt_entry[DATA_WIDTH];
  assign w_resp_data = w_resp && !read_prt_entry[DATA_WIDTH];

  // Cap reached, or reached by the byte landing this cycle: no further read may issue.
  assign w_at_cap  = (r_byte_cnt == CW'(MAX_FRAME));
  assign w_hit_cap = w_resp_data && (r_byte_cnt == CW'(MAX_FRAME - 1));

  assign w_credit    = (r_fifo_cnt + (AW+1)'(r_inflight)) < (AW+1)'(FIFO_DEPTH);
  assign w_room      = r_fifo_cnt < (AW+1)'(FIFO_DEPTH);
  assign w_slot_free = !r_inflight || w_resp;

  assign w_en_read = (r_state == S_READ) && RDY_read_prt_entry && w_credit && w_slot_free &&
                     !w_resp_cmpl && !w_at_cap && !w_hit_cap;

  assign w_ovr_push  = (r_state == S_READ) && w_at_cap && !r_inflight && w_room;
  assign w_push      = (w_resp && r_stage_vld) || w_ovr_push;
  assign w_push_last = w_resp_cmpl || w_ovr_push;

  assign w_fifo_vld = (r_fifo_cnt != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = w_fifo_vld && tx_ready;

  assign slot_in_ready                = (r_state == S_IDLE);
  assign EN_start_reading_prt_entry   = (r_state == S_START) && RDY_start_reading_prt_entry;
  assign start_reading_prt_entry_slot = r_cur_slot;
  assign EN_read_prt_entry            = w_en_read;
  assign EN_invalidate_prt_entry      = (r_state == S_INVAL) && RDY_invalidate_prt_entry;
  assign invalidate_prt_entry_slot    = r_cur_slot;
  assign tx_valid    = w_fifo_vld;
  assign tx_data     = w_fifo_vld ? w_head[DATA_WIDTH-1:0] : '0;
  assign tx_last     = w_fifo_vld && w_head[DATA_WIDTH];
  assign busy        = (r_state != S_IDLE) || w_fifo_vld;
  assign err_overrun = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cur_slot  <= '0;
      r_inflight  <= 1'b0;
      r_stage_vld <= 1'b0;
      r_stage     <= '0;
      r_byte_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= w_en_read;
      r_err      <= w_ovr_push;
      unique case (r_state)
        S_IDLE: begin
          if (slot_in_valid) begin
            r_cur_slot <= slot_in;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (RDY_start_reading_prt_entry) begin
            r_state     <= S_READ;
            r_byte_cnt  <= '0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
          end
        end
        S_READ: begin
          if (w_resp_data) begin
            r_stage     <= read_prt_entry[DATA_WIDTH-1:0];
            r_stage_vld <= 1'b1;
            r_byte_cnt  <= r_byte_cnt + CW'(1);
          end
          if (w_resp_cmpl || w_ovr_push) begin
            r_state <= S_INVAL;
          end
        end
        S_INVAL: begin
          if (RDY_invalidate_prt_entry) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_push_last, r_stage};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

`ifdef PRT_TX_STATS_EN
  logic [15:0] r_frames_sent;
  logic [15:0] r_bytes_sent;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frames_sent <= '0;
      r_bytes_sent  <= '0;
    end else if (w_pop) begin
      r_bytes_sent <= r_bytes_sent + 16'd1;
      if (w_head[DATA_WIDTH]) begin
        r_frames_sent <= r_frames_sent + 16'd1;
      end
    end
  end

  assign frames_sent = r_frames_sent;
  assign bytes_sent  = r_bytes_sent;
`else
  assign frames_sent = '0;
  assign bytes_sent  = '0;
`endif

endmodule

// File: tb/tb_prt_frame_tx.sv
// Scoreboard bench for prt_frame_tx: behavioural PRT model, expected-beat queue
// filled at slot issue, negedge monitor comparing every tx handshake.
module tb_prt_frame_tx;
  localparam int DW   = 8;
  localparam int NS   = 2;
  localparam int MAXF = 1518;
  localparam int FD   = 4;
  localparam int SW   = 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [SW-1:0] slot_in;
  logic          slot_in_valid;
  logic          slot_in_ready;
  logic          EN_start_reading_prt_entry;
  logic [SW-1:0] start_reading_prt_entry_slot;
  logic          RDY_start_reading_prt_entry;
  logic          EN_read_prt_entry;
  logic          RDY_read_prt_entry;
  logic [DW:0]   read_prt_entry;
  logic          EN_invalidate_prt_entry;
  logic [SW-1:0] invalidate_prt_entry_slot;
  logic          RDY_invalidate_prt_entry;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready;
  logic          busy;
  logic          err_overrun;
  logic [15:0]   frames_sent;
  logic [15:0]   bytes_sent;

  always #5 CLK = ~CLK;

  prt_frame_tx #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_FRAME(MAXF), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RST(RST),
    .slot_in(slot_in), .slot_in_valid(slot_in_valid), .slot_in_ready(slot_in_ready),
    .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
    .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
    .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
    .EN_read_prt_entry(EN_read_prt_entry), .RDY_read_prt_entry(RDY_read_prt_entry),
    .read_prt_entry(read_prt_entry),
    .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
    .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
    .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .err_overrun(err_overrun),
    .frames_sent(frames_sent), .bytes_sent(bytes_sent)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stored frames, one per slot
  logic [7:0] sdata [NS][1600];
  int         slen  [NS];
  bit         sendl [NS];

  logic [8:0] exp_q  [$];
  int         open_q [$];
  int         inv_q  [$];
  int         rdn_q  [$];

  int  cyc = 0;
  int  beats = 0, data_reads = 0, read_cnt = 0;
  int  exp_frames = 0, exp_bytes = 0, err_cnt = 0, start_cnt = 0;
  int  t_start, t_rd, t_first, t_last, t_inv;
  bit  hold_start = 0, hold_inv = 0, rnd_rdy = 0, rnd_rd = 0;
  int  tx_mode = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Ready driver for start/invalidate handshakes and the tx sink
  initial begin
    RDY_start_reading_prt_entry = 1'b1;
    RDY_invalidate_prt_entry    = 1'b1;
    tx_ready                    = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      RDY_start_reading_prt_entry = hold_start ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      RDY_invalidate_prt_entry    = hold_inv   ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      case (tx_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Behavioural PRT: open/read/invalidate methods with one-cycle read latency
  initial begin : prt_model
    logic          st, rd, inv, prev_st, prev_inv;
    logic [SW-1:0] sts, invs;
    logic [8:0]    resp;
    int            open_slot, rd_idx;
    prev_st = 0; prev_inv = 0; open_slot = 0; rd_idx = 0; resp = '0;
    read_prt_entry     = '0;
    RDY_read_prt_entry = 1'b1;
    forever begin
      @(posedge CLK);
      st = EN_start_reading_prt_entry;   sts  = start_reading_prt_entry_slot;
      rd = EN_read_prt_entry;
      inv = EN_invalidate_prt_entry;     invs = invalidate_prt_entry_slot;
      if (RST) begin
        read_cnt = 0; rd_idx = 0; data_reads = 0; beats = 0;
        prev_st = 0; prev_inv = 0; rd = 0;
      end else begin
        if (st) begin
          chk("start_rdy", 32'(RDY_start_reading_prt_entry), 1);
          chk("start_pulse", 32'(prev_st), 0);
          if (open_q.size() == 0) chk("start_unexpected", 1, 0);
          else chk("start_slot", 32'(sts), 32'(open_q.pop_front()));
          open_slot = int'(sts);
          rd_idx = 0;
        end
        if (rd) begin
          chk("read_rdy", 32'(RDY_read_prt_entry), 1);
          read_cnt++;
          if (!sendl[open_slot] && rd_idx >= slen[open_slot]) begin
            resp = {1'b1, 8'h00};
          end else begin
            resp = {1'b0, sdata[open_slot][rd_idx]};
            data_reads++;
            chk("credit", 32'(data_reads - beats <= FD + 1), 1);
          end
          rd_idx++;
        end
        if (inv) begin
          chk("inval_rdy", 32'(RDY_invalidate_prt_entry), 1);
          chk("inval_pulse", 32'(prev_inv), 0);
          if (inv_q.size() == 0) chk("inval_unexpected", 1, 0);
          else begin
            chk("inval_slot", 32'(invs), 32'(inv_q.pop_front()));
            chk("read_count", 32'(read_cnt), 32'(rdn_q.pop_front()));
          end
          read_cnt = 0;
        end
        prev_st = st; prev_inv = inv;
      end
      #1;
      read_prt_entry     = rd ? resp : 9'($urandom);
      RDY_read_prt_entry = rnd_rd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every tx handshake
  initial begin : monitor
    logic       prev_stall, prev_err;
    logic [8:0] prev_beat, e;
    prev_stall = 0; prev_err = 0; prev_beat = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_stall = 0; prev_err = 0;
      end else begin
`ifdef PRT_TX_STATS_EN
        chk("frames_sent", 32'(frames_sent), 32'(exp_frames & 16'hFFFF));
        chk("bytes_sent", 32'(bytes_sent), 32'(exp_bytes & 16'hFFFF));
`else
        chk("frames_sent", 32'(frames_sent), 0);
        chk("bytes_sent", 32'(bytes_sent), 0);
`endif
        if (tx_valid && prev_stall) chk("stall_stable", 32'({tx_last, tx_data}), 32'(prev_beat));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 32'({tx_last, tx_data}), 32'h1FF);
          else begin
            e = exp_q.pop_front();
            chk("beat", 32'({tx_last, tx_data}), 32'(e));
            exp_bytes++;
            if (e[8]) exp_frames++;
          end
          beats++;
          if (t_first < 0) t_first = cyc;
          if (tx_last) t_last = cyc;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_beat  = {tx_last, tx_data};
        if (err_overrun) begin
          err_cnt++;
          chk("err_pulse", 32'(prev_err), 0);
        end
        prev_err = err_overrun;
        if (EN_start_reading_prt_entry) start_cnt++;
        if (EN_start_reading_prt_entry && t_start < 0) t_start = cyc;
        if (EN_read_prt_entry && t_rd < 0) t_rd = cyc;
        if (EN_invalidate_prt_entry && t_inv < 0) t_inv = cyc;
      end
    end
  end

  task automatic clear_marks();
    t_start = -1; t_rd = -1; t_first = -1; t_last = -1; t_inv = -1;
  endtask

  // Called in the #1-after-posedge phase; returns in the same phase
  int t_acc;
  task automatic send(input int slot, input int len, input bit endless, input bit rnd);
    int n, nb;
    n = 0;
    while (!slot_in_ready && n < 5000) begin @(posedge CLK); #1; n++; end
    if (n >= 5000) chk("accept_timeout", 0, 1);
    for (int i = 0; i < 1600; i++)
      sdata[slot][i] = rnd ? 8'($urandom) : 8'(i);
    slen[slot]  = len;
    sendl[slot] = endless;
    nb = endless ? MAXF : len;
    for (int i = 0; i < nb; i++) exp_q.push_back({i == nb - 1, sdata[slot][i]});
    open_q.push_back(slot);
    inv_q.push_back(slot);
    rdn_q.push_back(endless ? MAXF : len + 1);
    if (endless) exp_frames = exp_frames;
    slot_in       = SW'(slot);
    slot_in_valid = 1'b1;
    t_acc         = cyc;
    @(posedge CLK); #1;
    slot_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || inv_q.size() != 0) && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete(); open_q.delete(); inv_q.delete(); rdn_q.delete();
    exp_frames = 0; exp_bytes = 0;
    @(negedge CLK);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_en_start", 32'(EN_start_reading_prt_entry), 0);
    chk("rst_en_read", 32'(EN_read_prt_entry), 0);
    chk("rst_en_inval", 32'(EN_invalidate_prt_entry), 0);
    chk("rst_slot_ready", 32'(slot_in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_bytes", 32'(bytes_sent), 0);
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int n, s0, e0, t_rdy;
    RST = 1'b1; slot_in = '0; slot_in_valid = 1'b0;
    clear_marks();
    repeat (2) @(posedge CLK);
    #1;
    reset_dut();

    // 64-byte frame, all ready: latency profile
    clear_marks();
    send(1, 64, 0, 0);
    n = 0;
    while (!slot_in_ready && n < 500) begin @(posedge CLK); #1; n++; end
    t_rdy = cyc;
    wait_done(500);
    chk("lat_en_start", 32'(t_start - t_acc), 1);
    chk("lat_first_read", 32'(t_rd - t_acc), 2);
    chk("lat_first_beat", 32'(t_first - t_acc), 5);
    chk("lat_last_beat", 32'(t_last - t_acc), 4 + 64);
    chk("lat_inval", 32'(t_inv - t_acc), 4 + 64);
    chk("lat_slot_ready", 32'(t_rdy - t_acc), 5 + 64);

    // Same frame with tx_ready toggling
    tx_mode = 1;
    send(1, 64, 0, 0);
    wait_done(1000);
    tx_mode = 0;

    // Zero-length frame on slot 0
    s0 = exp_frames;
    send(0, 0, 0, 0);
    wait_done(200);
    chk("zero_len_frames", 32'(exp_frames), 32'(s0));

    // Never-completing frame: overrun at the cap
    e0 = err_cnt;
    send(0, 0, 1, 0);
    wait_done(5000);
    chk("overrun_pulses", 32'(err_cnt), 32'(e0 + 1));

    // Start and invalidate handshakes held off
    hold_start = 1; hold_inv = 1;
    s0 = start_cnt;
    send(1, 10, 0, 1);
    repeat (10) @(posedge CLK);
    #1;
    chk("start_held", 32'(start_cnt), 32'(s0));
    hold_start = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
    repeat (5) @(posedge CLK);
    #1;
    chk("inval_held", 32'(inv_q.size()), 1);
    hold_inv = 0;
    wait_done(200);

    // Randomized traffic and backpressure
    rnd_rdy = 1; rnd_rd = 1; tx_mode = 2;
    for (int i = 0; i < 12; i++)
      send($urandom_range(0, NS - 1), $urandom_range(0, 40), 0, 1);
    wait_done(5000);
    rnd_rdy = 0; rnd_rd = 0; tx_mode = 0;

    // Reset mid-frame, then a clean frame
    send(1, 64, 0, 0);
    n = 0;
    while (exp_q.size() > 44 && n < 200) begin @(posedge CLK); #1; n++; end
    chk("mid_reset_reach", 32'(exp_q.size() <= 44), 1);
    reset_dut();
    send(0, 8, 0, 1);
    wait_done(200);
`ifdef PRT_TX_STATS_EN
    chk("post_rst_frames", 32'(frames_sent), 1);
    chk("post_rst_bytes", 32'(bytes_sent), 8);
`else
    chk("post_rst_frames", 32'(frames_sent), 0);
`endif

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
